// File: rtl/conv_enc_framer_pkg.sv
// -----------------------------------------------------------------------------
// conv_enc_framer_pkg
// Shared constants for the rate-1/2, K=9 convolutional encoder framer:
//   CE_K     - default constraint length
//   WD_CODE  - code symbol width (rate 1/2 -> 2 bits, not overridable)
//   CE_G0    - default generator for Code[1] (bit K-1 taps the current bit)
//   CE_G1    - default generator for Code[0]
//   state_t  - framer FSM encoding (IDLE=0, DATA=1, TAIL=2)
// -----------------------------------------------------------------------------
package conv_enc_framer_pkg;

   localparam int             CE_K    = 9;
   localparam int             WD_CODE = 2;
   localparam logic [CE_K-1:0] CE_G0  = 9'o561;
   localparam logic [CE_K-1:0] CE_G1  = 9'o753;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      TAIL = 2'd2
   } state_t;

endpackage

// File: rtl/conv_enc_framer_core.sv
// -----------------------------------------------------------------------------
// conv_enc_core
// Purely combinational parity stage of the convolutional encoder.
// Forms s = {b, sr} and produces {^(s & G0), ^(s & G1)}.
// Ports:
//   b     in  1        next input bit (lands on s[K-1])
//   sr    in  K-1      previous bits, most recent in sr[K-2]
//   code  out WD_CODE  {G0 parity, G1 parity}
// -----------------------------------------------------------------------------
module conv_enc_core
   import conv_enc_framer_pkg::*;
#(
   parameter int             K  = CE_K,
   parameter logic [K-1:0]   G0 = CE_G0,
   parameter logic [K-1:0]   G1 = CE_G1
) (
   input  logic               b,
   input  logic [K-2:0]       sr,
   output logic [WD_CODE-1:0] code
);

   logic [K-1:0] s;
   logic [K-1:0] tap0;
   logic [K-1:0] tap1;

   assign s = {b, sr};

   generate
      for (genvar gi = 0; gi < K; gi++) begin : g_tap
         assign tap0[gi] = s[gi] & G0[gi];
         assign tap1[gi] = s[gi] & G1[gi];
      end
   endgenerate

   assign code = {^tap0, ^tap1};

endmodule

// File: rtl/conv_enc_framer.sv
// -----------------------------------------------------------------------------
// conv_enc_framer
// Rate-1/2 convolutional encoder with byte framing and K-1 zero tail bits,
// driving the Viterbi decoder symbol input directly.
// Optional build macro: CONV_ENC_ERR_INJECT_EN adds err_mask, XORed onto Code
// while Active (channel-error reproduction). Default build has no such port.
// Ports:
//   CLOCK     in   1        system clock
//   Reset     in   1        asynchronous, active-low reset
//   err_mask  in   WD_CODE  (CONV_ENC_ERR_INJECT_EN only) symbol error mask
//   in_data   in   8        byte to encode, MSB first
//   in_valid  in   1        in_data valid
//   in_last   in   1        in_data is the final byte of the frame
//   in_ready  out  1        a byte can be accepted this cycle
//   Code      out  WD_CODE  current symbol {G0 parity, G1 parity}
//   code_stb  out  1        pulse in the first cycle of each new symbol
//   Active    out  1        frame in progress
//   underrun  out  1        sticky: frame cut short by input starvation
// SYM_DIV (clock cycles per symbol) must be at least 2.
// -----------------------------------------------------------------------------
module conv_enc_framer
   import conv_enc_framer_pkg::*;
#(
   parameter int           K       = CE_K,
   parameter logic [K-1:0] G0      = CE_G0,
   parameter logic [K-1:0] G1      = CE_G1,
   parameter int           SYM_DIV = 16
) (
   input  logic               CLOCK,
   input  logic               Reset,
`ifdef CONV_ENC_ERR_INJECT_EN
   input  logic [WD_CODE-1:0] err_mask,
`endif
   input  logic [7:0]         in_data,
   input  logic               in_valid,
   input  logic               in_last,
   output logic               in_ready,
   output logic [WD_CODE-1:0] Code,
   output logic               code_stb,
   output logic               Active,
   output logic               underrun
);

   localparam int DIV_W = $clog2(SYM_DIV);
   localparam int TW    = $clog2(K);

   state_t               state_reg,     state_next;
   logic [K-2:0]         sr_reg,        sr_next;
   logic [DIV_W-1:0]     div_reg,       div_next;
   logic [7:0]           cur_reg,       cur_next;
   logic                 cur_last_reg,  cur_last_next;
   logic [7:0]           hold_reg,      hold_next;
   logic                 hold_full_reg, hold_full_next;
   logic                 hold_last_reg, hold_last_next;
   logic [3:0]           bit_idx_reg,   bit_idx_next;
   logic [TW-1:0]        tail_cnt_reg,  tail_cnt_next;
   logic [WD_CODE-1:0]   code_reg,      code_next;
   logic                 stb_reg,       stb_next;
   logic                 active_reg,    active_next;
   logic                 underrun_reg,  underrun_next;

   logic                 xfer;
   logic                 tick;
   logic                 boundary;
   logic                 issue;
   logic                 b_bit;
   logic [WD_CODE-1:0]   enc_code;

   conv_enc_core #(
      .K  (K),
      .G0 (G0),
      .G1 (G1)
   ) u_core (
      .b    (b_bit),
      .sr   (sr_reg),
      .code (enc_code)
   );

   // Once the final byte sits in cur, nothing more is taken until the frame
   // has drained, so the next frame can never be parked in hold.
   assign in_ready = ~hold_full_reg &
                     ((state_reg == IDLE) | ((state_reg == DATA) & ~cur_last_reg));
   assign xfer     = in_valid & in_ready;
   assign tick     = (div_reg == DIV_W'(SYM_DIV - 1));
   assign boundary = tick & (bit_idx_reg == 4'd8);

   always_comb begin
      state_next     = state_reg;
      sr_next        = sr_reg;
      div_next       = div_reg;
      cur_next       = cur_reg;
      cur_last_next  = cur_last_reg;
      hold_next      = hold_reg;
      hold_full_next = hold_full_reg;
      hold_last_next = hold_last_reg;
      bit_idx_next   = bit_idx_reg;
      tail_cnt_next  = tail_cnt_reg;
      code_next      = code_reg;
      stb_next       = 1'b0;
      active_next    = active_reg;
      underrun_next  = underrun_reg;
      issue          = 1'b0;
      b_bit          = 1'b0;

      if (state_reg != IDLE) begin
         div_next = tick ? '0 : div_reg + 1'b1;
      end

      // Fill hold mid-byte; a byte arriving exactly on the boundary goes
      // straight into cur below instead.
      if ((state_reg == DATA) && xfer && !boundary) begin
         hold_next      = in_data;
         hold_full_next = 1'b1;
         hold_last_next = in_last;
      end

      case (state_reg)
         IDLE: begin
            if (xfer) begin
               issue         = 1'b1;
               b_bit         = in_data[7];
               cur_next      = {in_data[6:0], 1'b0};
               cur_last_next = in_last;
               bit_idx_next  = 4'd1;
               div_next      = '0;
               active_next   = 1'b1;
               underrun_next = 1'b0;
               state_next    = DATA;
            end
         end

         DATA: begin
            if (tick) begin
               issue = 1'b1;
               if (bit_idx_reg != 4'd8) begin
                  b_bit        = cur_reg[7];
                  cur_next     = {cur_reg[6:0], 1'b0};
                  bit_idx_next = bit_idx_reg + 4'd1;
               end else if (cur_last_reg) begin
                  tail_cnt_next = TW'(1);
                  state_next    = TAIL;
               end else if (hold_full_reg) begin
                  b_bit          = hold_reg[7];
                  cur_next       = {hold_reg[6:0], 1'b0};
                  cur_last_next  = hold_last_reg;
                  hold_full_next = 1'b0;
                  bit_idx_next   = 4'd1;
               end else if (xfer) begin
                  b_bit         = in_data[7];
                  cur_next      = {in_data[6:0], 1'b0};
                  cur_last_next = in_last;
                  bit_idx_next  = 4'd1;
               end else begin
                  // Starved: close the frame with a normal tail.
                  underrun_next = 1'b1;
                  tail_cnt_next = TW'(1);
                  state_next    = TAIL;
               end
            end
         end

         TAIL: begin
            if (tick) begin
               if (tail_cnt_reg == TW'(K - 1)) begin
                  // Last tail period has expired; sr is all zero again.
                  code_next     = '0;
                  active_next   = 1'b0;
                  tail_cnt_next = '0;
                  state_next    = IDLE;
               end else begin
                  issue         = 1'b1;
                  tail_cnt_next = tail_cnt_reg + 1'b1;
               end
            end
         end

         default: begin
            state_next  = IDLE;
            code_next   = '0;
            active_next = 1'b0;
         end
      endcase

      if (issue) begin
         code_next = enc_code;
         sr_next   = {b_bit, sr_reg[K-2:1]};
         stb_next  = 1'b1;
      end
   end

   always_ff @(posedge CLOCK or negedge Reset) begin
      if (!Reset) begin
         state_reg     <= IDLE;
         sr_reg        <= '0;
         div_reg       <= '0;
         cur_reg       <= '0;
         cur_last_reg  <= 1'b0;
         hold_reg      <= '0;
         hold_full_reg <= 1'b0;
         hold_last_reg <= 1'b0;
         bit_idx_reg   <= '0;
         tail_cnt_reg  <= '0;
         code_reg      <= '0;
         stb_reg       <= 1'b0;
         active_reg    <= 1'b0;
         underrun_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         sr_reg        <= sr_next;
         div_reg       <= div_next;
         cur_reg       <= cur_next;
         cur_last_reg  <= cur_last_next;
         hold_reg      <= hold_next;
         hold_full_reg <= hold_full_next;
         hold_last_reg <= hold_last_next;
         bit_idx_reg   <= bit_idx_next;
         tail_cnt_reg  <= tail_cnt_next;
         code_reg      <= code_next;
         stb_reg       <= stb_next;
         active_reg    <= active_next;
         underrun_reg  <= underrun_next;
      end
   end

`ifdef CONV_ENC_ERR_INJECT_EN
   assign Code = code_reg ^ (active_reg ? err_mask : '0);
`else
   assign Code = code_reg;
`endif
   assign code_stb = stb_reg;
   assign Active   = active_reg;
   assign underrun = underrun_reg;

endmodule

// File: tb/tb_conv_enc_framer.sv
// -----------------------------------------------------------------------------
// tb_conv_enc_framer
// Directed, table-driven bench for conv_enc_framer: each table row is one
// frame (bytes, in_last, expected symbol count, expected underrun, optional
// hand-computed leading symbols). Symbols are also compared against a
// sliding-window convolution model. A hand-written sequence covers reset in
// the middle of a frame followed by a clean impulse frame.
// -----------------------------------------------------------------------------
module tb_conv_enc_framer;

   localparam int         SYM_DIV = 16;
   localparam int         BOUND   = 40 * SYM_DIV;
   localparam logic [8:0] TG0     = 9'o561;
   localparam logic [8:0] TG1     = 9'o753;

   logic       CLOCK    = 1'b0;
   logic       Reset    = 1'b0;
   logic [7:0] in_data  = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_last  = 1'b0;
   logic       in_ready;
   logic [1:0] Code;
   logic       code_stb;
   logic       Active;
   logic       underrun;
`ifdef CONV_ENC_ERR_INJECT_EN
   logic [1:0] err_mask = 2'b00;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      string       name;
      int          nbytes;
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic        last;
      int          nsym;
      logic        exp_ur;
      bit          has_head;
      logic [17:0] head;
   } vec_t;

   vec_t       vecs[6];
   logic [1:0] got[64];
   bit         ub[64];
   logic       prev_ur = 1'b0;

   always #5 CLOCK = ~CLOCK;

   conv_enc_framer #(
      .SYM_DIV (SYM_DIV)
   ) dut (
      .CLOCK    (CLOCK),
      .Reset    (Reset),
`ifdef CONV_ENC_ERR_INJECT_EN
      .err_mask (err_mask),
`endif
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_last  (in_last),
      .in_ready (in_ready),
      .Code     (Code),
      .code_stb (code_stb),
      .Active   (Active),
      .underrun (underrun)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Symbol j of the reference: output taps G[8-t] against input bit j-t.
   function automatic logic [1:0] ref_sym(input int j);
      logic c1, c0;
      c1 = 1'b0;
      c0 = 1'b0;
      for (int t = 0; t < 9; t++) begin
         if (j - t >= 0) begin
            c1 ^= TG0[8-t] & ub[j-t];
            c0 ^= TG1[8-t] & ub[j-t];
         end
      end
      return {c1, c0};
   endfunction

   task automatic run_frame(input int v);
      int          nstb, drop, spacing_err, unstable, nbits;
      logic [1:0]  last_code;
      logic [7:0]  by;
      logic [17:0] hd;
      vec_t        r;
      r = vecs[v];

      nbits = 0;
      for (int n = 0; n < r.nbytes; n++) begin
         by = (n == 0) ? r.b0 : r.b1;
         for (int k = 7; k >= 0; k--) begin
            ub[nbits] = by[k];
            nbits++;
         end
      end
      for (int k = 0; k < 8; k++) begin
         ub[nbits] = 1'b0;
         nbits++;
      end

      @(negedge CLOCK);
      chk({r.name, "_ready_idle"}, in_ready, 1);
      chk({r.name, "_underrun_before"}, underrun, prev_ur);
      in_data  = r.b0;
      in_valid = 1'b1;
      in_last  = (r.nbytes == 1) ? r.last : 1'b0;
      @(posedge CLOCK);

      nstb = 0; drop = -1; spacing_err = 0; unstable = 0; last_code = 2'b00;
      for (int i = 0; i < BOUND; i++) begin
         @(negedge CLOCK);
         if (i == 0) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
            chk({r.name, "_first_stb"}, code_stb, 1);
            chk({r.name, "_active_start"}, Active, 1);
            chk({r.name, "_underrun_clr"}, underrun, 0);
         end
         if (r.nbytes == 2 && i == 20) begin
            chk({r.name, "_ready_hold_empty"}, in_ready, 1);
            in_data  = r.b1;
            in_valid = 1'b1;
            in_last  = r.last;
         end
         if (r.nbytes == 2 && i == 21) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
            chk({r.name, "_ready_hold_full"}, in_ready, 0);
         end
         if (!Active) begin
            drop = i;
            break;
         end
         if (code_stb) begin
            if (i != nstb * SYM_DIV) spacing_err++;
            if (nstb < 64) got[nstb] = Code;
            nstb++;
            last_code = Code;
         end else if (Code !== last_code) begin
            unstable++;
         end
      end

      chk({r.name, "_active_drop_cycle"}, drop, r.nsym * SYM_DIV);
      if (drop >= 0) chk({r.name, "_code_zero_idle"}, Code, 0);
      chk({r.name, "_strobe_count"}, nstb, r.nsym);
      chk({r.name, "_spacing"}, spacing_err, 0);
      chk({r.name, "_code_stable"}, unstable, 0);
      chk({r.name, "_underrun_end"}, underrun, r.exp_ur);
      for (int j = 0; j < r.nsym && j < nstb && j < 64; j++)
         chk($sformatf("%s_sym%0d", r.name, j), got[j], ref_sym(j));
      if (r.has_head) begin
         hd = r.head;
         for (int j = 0; j < 9 && j < nstb; j++)
            chk($sformatf("%s_hand_sym%0d", r.name, j), got[j], hd[17-2*j -: 2]);
      end
      prev_ur = r.exp_ur;
      $display("frame %s: %0d symbols, active drop at cycle %0d, underrun=%0b",
               r.name, nstb, drop, underrun);
   endtask

   initial begin
      vecs[0] = '{"impulse",  1, 8'h80, 8'h00, 1'b1, 16, 1'b0, 1'b1, 18'b11_01_11_11_10_01_00_01_11};
      vecs[1] = '{"b2b",      2, 8'hA5, 8'h3C, 1'b1, 24, 1'b0, 1'b0, 18'd0};
      vecs[2] = '{"starve1",  1, 8'hFF, 8'h00, 1'b0, 16, 1'b1, 1'b0, 18'd0};
      vecs[3] = '{"zeros",    1, 8'h00, 8'h00, 1'b1, 16, 1'b0, 1'b1, 18'd0};
      vecs[4] = '{"single",   1, 8'hC3, 8'h00, 1'b1, 16, 1'b0, 1'b0, 18'd0};
      vecs[5] = '{"starve2",  2, 8'h5A, 8'hF0, 1'b0, 24, 1'b1, 1'b0, 18'd0};

      // Reset state
      repeat (3) @(negedge CLOCK);
      chk("reset_code", Code, 0);
      chk("reset_active", Active, 0);
      chk("reset_stb", code_stb, 0);
      chk("reset_underrun", underrun, 0);
      chk("reset_ready", in_ready, 1);
      Reset = 1'b1;
      repeat (2) @(negedge CLOCK);

      for (int v = 0; v < 6; v++) begin
         run_frame(v);
         repeat (3) @(negedge CLOCK);
      end

      // Reset in the middle of a 0x55 frame, at the 5th symbol.
      @(negedge CLOCK);
      in_data  = 8'h55;
      in_valid = 1'b1;
      in_last  = 1'b1;
      @(posedge CLOCK);
      @(negedge CLOCK);
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (4 * SYM_DIV) @(negedge CLOCK);
      chk("midreset_sym5_stb", code_stb, 1);
      chk("midreset_active_before", Active, 1);
      Reset = 1'b0;
      #1;
      chk("midreset_code", Code, 0);
      chk("midreset_active", Active, 0);
      chk("midreset_ready", in_ready, 1);
      chk("midreset_stb", code_stb, 0);
      $display("frame midreset: reset asserted at symbol 5, Code=%0b Active=%0b", Code, Active);
      repeat (2) @(negedge CLOCK);
      Reset = 1'b1;
      repeat (2 * SYM_DIV) @(negedge CLOCK);
      chk("midreset_no_tail", Active, 0);
      prev_ur = 1'b0;
      run_frame(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
